// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants for the timing generator and the pixel memory driver.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: [START, END).
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_pixel_clk_div.sv
// Divides clk into a one-cycle pixel strobe and a 50%-duty pixel clock for the DAC.
module vga_pixel_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic adv_o,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            pix_en_q, vga_clk_q;

    // adv_o marks the edge on which the raster counters and pix_en update together.
    assign adv_o = (div_cnt_q == CntLast);

    always_comb begin
        div_cnt_d = adv_o ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= adv_o;
            vga_clk_q <= (div_cnt_d >= CntHalf);
        end
    end

    assign pix_en_o  = pix_en_q;
    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: x/y counters with registered sync, blank and frame-tick decodes.
module vga_timing_gen
    import vga_timing_pkg::CNT_W;
#(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             active_pixels_o,
    output logic             vga_hs_o,
    output logic             vga_vs_o,
    output logic             vga_blank_n_o,
    output logic             vga_sync_n_o,
    output logic             vga_clk_o,
    output logic             pix_en_o,
    output logic             frame_tick_o
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] XLast   = CNT_W'(HTotal - 1);
    localparam logic [CNT_W-1:0] YLast   = CNT_W'(VTotal - 1);
    localparam logic [CNT_W-1:0] XAct    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] YAct    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] YFrame  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             adv;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             active_q, active_d;
    logic             hs_n_q, hs_n_d;
    logic             vs_n_q, vs_n_d;
    logic             frame_tick_q, frame_tick_d;

    vga_pixel_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .adv_o     (adv),
        .pix_en_o  (pix_en_o),
        .vga_clk_o (vga_clk_o)
    );

    // Decodes use the next counter values so every output lines up with the registered x/y.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_tick_d = 1'b0;
        if (adv) begin
            if (x_q == XLast) begin
                x_d          = '0;
                y_d          = (y_q == YLast) ? '0 : y_q + 1'b1;
                frame_tick_d = (y_q == YFrame);
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        active_d = (x_d < XAct) && (y_d < YAct);
        hs_n_d   = !((x_d >= HsStart) && (x_d < HsEnd));
        vs_n_d   = !((y_d >= VsStart) && (y_d < VsEnd));
    end

    // Reset parks the raster on the last pixel of a frame so all decodes stay consistent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q          <= XLast;
            y_q          <= YLast;
            active_q     <= 1'b0;
            hs_n_q       <= 1'b1;
            vs_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            active_q     <= active_d;
            hs_n_q       <= hs_n_d;
            vs_n_q       <= vs_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x_o             = x_q;
    assign y_o             = y_q;
    assign active_pixels_o = active_q;
    assign vga_blank_n_o   = active_q;
    assign vga_hs_o        = hs_n_q;
    assign vga_vs_o        = vs_n_q;
    assign vga_sync_n_o    = 1'b0;
    assign frame_tick_o    = frame_tick_q;

endmodule
